// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply or restoring divide over XLEN
// cycles, then a one-cycle sign fixup. Divide-by-zero and signed overflow complete immediately.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            flush,
  output logic            busy,
  output logic            resp_valid,
  output logic [XLEN-1:0] result,
  output logic [1:0]      fsm_state
);

  // Handshake: a request is taken on a cycle where req_valid & req_ready & ~flush; the
  // response is a single-cycle resp_valid pulse, and result holds until the next accept.
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  state_t              state, state_next;
  logic [2:0]          op_q;
  logic                neg_prod_q, neg_quo_q, neg_rem_q;
  logic [XLEN-1:0]     b_mag_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [CNT_W-1:0]    count_q;

  logic                accept, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                div_zero, div_ovf, special;
  logic [XLEN-1:0]     special_result;

  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next, div_next, prod;
  logic [XLEN:0]       rem_sh;
  logic [XLEN-1:0]     diff, quo, rem, fix_result;

  assign req_ready  = (state == IDLE) & ~rst;
  assign busy       = (state != IDLE);
  assign resp_valid = (state == DONE) & ~flush & ~rst;
  assign fsm_state  = state;
  assign accept     = req_valid & req_ready & ~flush;

  // Operand signedness by op: MULH/DIV/REM both signed, MULHSU only rs1.
  assign a_signed = (func3 == 3'b001) | (func3 == 3'b010) | (func3 == 3'b100) | (func3 == 3'b110);
  assign b_signed = (func3 == 3'b001) | (func3 == 3'b100) | (func3 == 3'b110);
  assign a_neg    = a_signed & operand1[XLEN-1];
  assign b_neg    = b_signed & operand2[XLEN-1];
  assign a_mag    = a_neg ? (~operand1 + 1'b1) : operand1;
  assign b_mag    = b_neg ? (~operand2 + 1'b1) : operand2;

  assign div_zero = (operand2 == '0);
  assign div_ovf  = ((func3 == 3'b100) | (func3 == 3'b110)) &
                    (operand1 == {1'b1, {(XLEN-1){1'b0}}}) & (operand2 == '1);
  assign special  = func3[2] & (div_zero | div_ovf);

  always_comb begin
    special_result = '0;
    if (div_zero) special_result = func3[1] ? operand1 : '1;
    else          special_result = func3[1] ? '0 : operand1;
  end

  // Multiply step: acc = {product_high, multiplier}; b_mag_q holds the multiplicand.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Divide step: acc = {remainder, quotient}; b_mag_q holds the divisor.
  assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign diff     = rem_sh[XLEN-1:0] - b_mag_q;
  assign div_next = (rem_sh >= {1'b0, b_mag_q}) ? {diff, acc_q[XLEN-2:0], 1'b1}
                                                 : {acc_q[2*XLEN-2:0], 1'b0};

  assign prod = neg_prod_q ? (~acc_q + 1'b1) : acc_q;
  assign quo  = neg_quo_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
  assign rem  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_result = '0;
    case (op_q)
      3'b000:                 fix_result = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_result = quo;
      default:                fix_result = rem;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = special ? DONE : CALC;
      CALC:    if (count_q == LAST) state_next = FIXUP;
      FIXUP:   state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      result     <= '0;
      count_q    <= '0;
      acc_q      <= '0;
      b_mag_q    <= '0;
      op_q       <= '0;
      neg_prod_q <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (accept) begin
          op_q       <= func3;
          neg_prod_q <= a_neg ^ b_neg;
          neg_quo_q  <= a_neg ^ b_neg;
          neg_rem_q  <= a_neg;
          count_q    <= '0;
          b_mag_q    <= func3[2] ? b_mag : a_mag;
          acc_q      <= {{XLEN{1'b0}}, (func3[2] ? a_mag : b_mag)};
          if (special) result <= special_result;
        end
        CALC: begin
          acc_q   <= op_q[2] ? div_next : mul_next;
          count_q <= count_q + 1'b1;
        end
        FIXUP: if (!flush) result <= fix_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer: table of ops with expected result and latency,
// plus hand sequences for reset, flush, mid-op reset and held req_valid.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, flush, busy, resp_valid;
  logic [2:0]  func3;
  logic [31:0] operand1, operand2, result;
  logic [1:0]  fsm_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_exp = '0;

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .func3(func3), .operand1(operand1), .operand2(operand2), .flush(flush),
    .busy(busy), .resp_valid(resp_valid), .result(result), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives the request in that cycle (cycle 0).
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cyc;
    bit seen;
    func3 = f; operand1 = a; operand2 = b; req_valid = 1'b1;
    chk({name, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    operand1 = $urandom; operand2 = $urandom; func3 = 3'($urandom_range(0, 7));
    cyc = 0; seen = 0;
    while (!seen && cyc < 60) begin
      @(negedge clk); cyc++;
      if (resp_valid) seen = 1;
    end
    chk({name, "_lat"}, 32'(cyc), 32'(lat));
    chk({name, "_result"}, result, exp);
    @(negedge clk);
    chk({name, "_pulse"}, 32'(resp_valid), 32'd0);
    chk({name, "_idle"}, 32'(req_ready), 32'd1);
    last_exp = exp;
  endtask

  initial begin
    int resp_cnt;
    vecs[0]  = '{"mul_7x6",       3'b000, 32'd7,          32'd6,          32'd42,         34};
    vecs[1]  = '{"mulhu_max",     3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  34};
    vecs[2]  = '{"mulh_m1x2",     3'b001, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  34};
    vecs[3]  = '{"mulhsu_m1x2",   3'b010, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  34};
    vecs[4]  = '{"mul_min_x2",    3'b000, 32'h8000_0000,  32'd2,          32'd0,          34};
    vecs[5]  = '{"div_m7_2",      3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
    vecs[6]  = '{"rem_m7_2",      3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
    vecs[7]  = '{"divu_100_7",    3'b101, 32'd100,        32'd7,          32'd14,         34};
    vecs[8]  = '{"remu_100_7",    3'b111, 32'd100,        32'd7,          32'd2,          34};
    vecs[9]  = '{"div_5_0",       3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[10] = '{"remu_5_0",      3'b111, 32'd5,          32'd0,          32'd5,          1};
    vecs[11] = '{"div_ovf",       3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[12] = '{"rem_ovf",       3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[13] = '{"mulh_min_min",  3'b001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  34};
    vecs[14] = '{"mulhsu_min_mx", 3'b010, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34};
    vecs[15] = '{"div_7_m2",      3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34};
    vecs[16] = '{"rem_7_m2",      3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          34};
    vecs[17] = '{"divu_max_1",    3'b101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34};

    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; func3 = '0; operand1 = '0; operand2 = '0;
    repeat (3) @(negedge clk);
    chk("ready_in_reset", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_resp", 32'(resp_valid), 32'd0);
    chk("reset_result", result, 32'd0);

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Flush during cycle 10 of a DIV, then a back-to-back request.
    resp_cnt = 0;
    func3 = 3'b100; operand1 = 32'd100; operand2 = 32'd7; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (resp_valid) resp_cnt++;
      if (c == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    chk("flush_no_resp", 32'(resp_cnt), 32'd0);
    chk("flush_ready", 32'(req_ready), 32'd1);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_result_held", result, last_exp);
    run_op("after_flush", 3'b111, 32'd100, 32'd7, 32'd2, 34);

    // Flush together with req_valid in IDLE must not accept.
    flush = 1'b1; req_valid = 1'b1; func3 = 3'b000; operand1 = 32'd3; operand2 = 32'd3;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_idle_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_idle_result", result, 32'd2);

    // Reset in cycle 20 of a MUL.
    resp_cnt = 0;
    func3 = 3'b000; operand1 = 32'd9; operand2 = 32'd9; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (resp_valid) resp_cnt++;
      if (c == 20) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_result", result, 32'd0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (resp_valid) resp_cnt++;
    end
    chk("rst_mid_no_resp", 32'(resp_cnt), 32'd0);

    // req_valid held while busy: one accept, one response.
    resp_cnt = 0;
    func3 = 3'b101; operand1 = 32'd100; operand2 = 32'd7; req_valid = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 2) begin operand1 = 32'd55; operand2 = 32'd5; end
      if (c == 34) req_valid = 1'b0;
      if (resp_valid) resp_cnt++;
    end
    chk("held_resp_count", 32'(resp_cnt), 32'd1);
    chk("held_result", result, 32'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
